branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direction predictor for the core's fetch stage.
- Fetch presents each fetched PC and receives a same-cycle taken/not-taken prediction.
- Execute stage returns the resolved outcome to train a table of 2-bit saturating counters.
- Keeps the prediction statistics (total/succeed/fail) that the core exports to the bench on its preds bus at completion.

Parameters:
- IDX_W, 6, log2 of pattern-table entries (64 entries); index = pc[IDX_W+1:2].
- HIST_W, 6, global history length; used only with GSHARE_EN; must satisfy HIST_W <= IDX_W.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- lookup_valid  in  1  fetch presents a branch PC this cycle.
- lookup_pc  in  32  PC of the fetched instruction.
- pred_taken  out  1  prediction for lookup_pc, combinational, same cycle.
- pred_ghr  out  HIST_W  history snapshot used for this lookup; fetch carries it down the pipe.
- upd_valid  in  1  execute resolves a conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_ghr  in  HIST_W  pred_ghr snapshot carried with that branch.
- upd_pred  in  1  prediction originally given for that branch.
- upd_taken  in  1  actual outcome.
- mispredict  out  1  combinational: upd_valid & (upd_pred != upd_taken).
- preds_total  out  CNT_W  resolved branches since reset.
- preds_succeed  out  CNT_W  correctly predicted branches.
- preds_fail  out  CNT_W  mispredicted branches.

Behaviour:
- Pattern table: 2^IDX_W flop-based 2-bit counters. Encoding SNT=0, WNT=1, WT=2, ST=3.
- Prediction: pred_taken = counter[msb] at the lookup index.
- Reads are asynchronous. When lookup_valid=0, pred_taken still reflects lookup_pc; fetch ignores it.
- Training on upd_valid: at the update index, taken increments saturating at ST; not-taken decrements saturating at SNT. The new value is visible from the next cycle.
- Same-index lookup and update in one cycle: lookup returns the pre-update value (no bypass).
- Statistics on upd_valid:
  - preds_total += 1.
  - preds_succeed += 1 if upd_pred == upd_taken, else preds_fail += 1.
  - Counters wrap modulo 2^CNT_W.
  - Invariant: total == succeed + fail.
- Reset: every table entry goes to WNT; all stats go to 0; GHR goes to 0; pred_ghr reads 0 (combinational from GHR).
- Reset wins over any simultaneous lookup or update. Reset may assert mid-stream; the cycle after deassertion behaves exactly as from power-up.
- Latency: prediction 0 cycles; training and stats 1 cycle.

Optional Feature:
- Macro GSHARE_EN.
- Defined:
  - Lookup index = pc[IDX_W+1:2] XOR zero-extended GHR; update index = upd_pc[IDX_W+1:2] XOR zero-extended upd_ghr.
  - GHR is a HIST_W-bit shift register with the newest bit in the LSB.
  - On lookup_valid, GHR <= {GHR[HIST_W-2:0], pred_taken}.
  - On mispredict, GHR <= {upd_ghr[HIST_W-2:0], upd_taken}; this takes priority over a same-cycle lookup shift.
  - pred_ghr = current GHR.
- Undefined: no GHR register; index = pc bits only; pred_ghr tied 0; upd_ghr ignored.

Decomposition:
- Package bp_pkg holds:
  - enum bp_cnt_t {SNT, WNT, WT, ST};
  - constant BP_CNT_RESET = WNT;
  - function sat_next(bp_cnt_t, logic taken) returning the saturated next state;
  - default IDX_W/HIST_W localparams.
- One sub-module bp_table: the counter array with one async read port and one write port, reset-to-WNT.
- Index hashing, GHR and stats stay in branch_predictor.

Test Plan:
- Reset, then lookup pc=0x40 -> pred_taken=0, pred_ghr=0; preds_total/succeed/fail = 0/0/0.
- Three updates pc=0x40, taken=1, upd_pred=0,1,1 -> counter WNT→WT→ST→ST; lookup 0x40 predicts 1 after the first update; stats 3/2/1.
- Four not-taken updates on pc=0x80 from reset -> counter saturates at SNT, never underflows; the next taken update gives WNT, still predicting 0.
- Same cycle lookup and update pc=0x40 (from WNT, taken) -> pred_taken=0 that cycle, 1 the next cycle.
- Assert rst for one cycle after training several entries -> all predictions 0, stats 0; training resumes normally on the next cycle.
- GSHARE_EN: lookup sequence grows GHR to 6'b000011; then a mispredict with upd_ghr=6'b000001, upd_taken=0 in the same cycle as a lookup -> GHR=6'b000010 next cycle, and the lookup shift is dropped.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch direction predictor.
// Counter encoding, reset value and the saturating-update rule live here.
package bp_pkg;

  localparam int IDX_W_DEF  = 6;
  localparam int HIST_W_DEF = 6;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_cnt_t;

  localparam bp_cnt_t BP_CNT_RESET = WNT;

  function automatic bp_cnt_t sat_next(bp_cnt_t cnt, logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = bp_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = bp_cnt_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bus of the branch predictor.
// master = core side (fetch + execute), slave = predictor.
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              lookup_valid;
  logic [31:0]       lookup_pc;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_pred;
  logic              upd_taken;
  logic              mispredict;
  logic [CNT_W-1:0]  preds_total;
  logic [CNT_W-1:0]  preds_succeed;
  logic [CNT_W-1:0]  preds_fail;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ghr, upd_pred, upd_taken,
    input  pred_taken, pred_ghr, mispredict, preds_total, preds_succeed, preds_fail
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ghr, upd_pred, upd_taken,
    output pred_taken, pred_ghr, mispredict, preds_total, preds_succeed, preds_fail
  );
endinterface

// File: rtl/bp_table.sv
// Pattern table of 2-bit saturating counters: one async read port and
// one read-modify-write training port; all entries reset to weakly not-taken.
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bp_cnt_t          o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  bp_cnt_t r_cnt [2**IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) r_cnt[i] <= BP_CNT_RESET;
    end else if (i_wr_en) begin
      r_cnt[i_wr_idx] <= sat_next(r_cnt[i_wr_idx], i_wr_taken);
    end
  end

  // No bypass: a same-cycle lookup sees the value before training.
  assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor: index hashing, optional global history and stats.
// Build option GSHARE_EN folds the global history register into the table index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int HIST_W = HIST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  bp_cnt_t          w_lk_cnt;
  logic             w_mispredict;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_succeed;
  logic [CNT_W-1:0] r_fail;
  logic             w_unused_pc;

  assign w_mispredict = bp.upd_valid & (bp.upd_pred != bp.upd_taken);
  assign w_unused_pc  = ^{bp.lookup_pc[31:IDX_W+2], bp.lookup_pc[1:0],
                          bp.upd_pc[31:IDX_W+2], bp.upd_pc[1:0]};

`ifdef GSHARE_EN
  logic [HIST_W-1:0] r_ghr;
  logic              w_unused_ghr;

  assign w_lk_idx     = bp.lookup_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_upd_idx    = bp.upd_pc[IDX_W+1:2] ^ IDX_W'(bp.upd_ghr);
  assign w_unused_ghr = bp.upd_ghr[HIST_W-1];

  // Mispredict repairs history from the branch's own snapshot; it beats a lookup shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_mispredict) begin
      r_ghr <= {bp.upd_ghr[HIST_W-2:0], bp.upd_taken};
    end else if (bp.lookup_valid) begin
      r_ghr <= {r_ghr[HIST_W-2:0], bp.pred_taken};
    end
  end

  assign bp.pred_ghr = r_ghr;
`else
  logic w_unused_ghr;

  assign w_lk_idx     = bp.lookup_pc[IDX_W+1:2];
  assign w_upd_idx    = bp.upd_pc[IDX_W+1:2];
  assign w_unused_ghr = ^{bp.upd_ghr, bp.lookup_valid};
  assign bp.pred_ghr  = '0;
`endif

  bp_table #(.IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_lk_idx),
    .o_rd_cnt   (w_lk_cnt),
    .i_wr_en    (bp.upd_valid),
    .i_wr_idx   (w_upd_idx),
    .i_wr_taken (bp.upd_taken)
  );

  assign bp.pred_taken = w_lk_cnt[1];
  assign bp.mispredict = w_mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total   <= '0;
      r_succeed <= '0;
      r_fail    <= '0;
    end else if (bp.upd_valid) begin
      r_total <= r_total + 1'b1;
      if (w_mispredict) r_fail    <= r_fail + 1'b1;
      else              r_succeed <= r_succeed + 1'b1;
    end
  end

  assign bp.preds_total   = r_total;
  assign bp.preds_succeed = r_succeed;
  assign bp.preds_fail    = r_fail;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table with a stats scoreboard,
// plus hand-written reset and global-history sequences.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk;
  logic rst;

  branch_predictor_if #(.HIST_W(6), .CNT_W(32)) bus ();

  branch_predictor #(.IDX_W(6), .HIST_W(6), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        up;
    logic        ut;
    logic [31:0] lpc;
    logic        exp_pred;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] f;
  } stats_t;

  vec_t   vecs [17];
  stats_t sb[$];
  int     checks = 0;
  int     errors = 0;
  logic [31:0] exp_t = 0, exp_s = 0, exp_f = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one vector, check same-cycle outputs, check stats one cycle later.
  task automatic apply(input vec_t v, input int n);
    stats_t e;
    stats_t got;
    bus.upd_valid = v.uv;
    bus.upd_pc    = v.upc;
    bus.upd_pred  = v.up;
    bus.upd_taken = v.ut;
    bus.lookup_pc = v.lpc;
    #1;
    check($sformatf("pred_taken[%0d]", n), {31'd0, bus.pred_taken}, {31'd0, v.exp_pred});
    check($sformatf("mispredict[%0d]", n), {31'd0, bus.mispredict}, {31'd0, v.exp_mis});
    if (v.uv) begin
      exp_t++;
      if (v.up == v.ut) exp_s++;
      else              exp_f++;
    end
    e.t = exp_t; e.s = exp_s; e.f = exp_f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    got = sb.pop_front();
    check($sformatf("total[%0d]", n),   bus.preds_total,   got.t);
    check($sformatf("succeed[%0d]", n), bus.preds_succeed, got.s);
    check($sformatf("fail[%0d]", n),    bus.preds_fail,    got.f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // uv upc up ut lpc exp_pred exp_mis
    vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h40,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40,  1'b0, 1'b1}; // same-cycle: old WNT
    vecs[2]  = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h40,  1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h80,  1'b0, 1'b1}; // SNT -> WNT
    vecs[10] = '{1'b0, 32'h80, 1'b1, 1'b0, 32'h80,  1'b0, 1'b0}; // no upd_valid: no mispredict
    vecs[11] = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h80,  1'b0, 1'b1}; // WNT -> WT
    vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h80,  1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'hC0,  1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h140, 1'b1, 1'b0}; // aliases 0x40
    vecs[15] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h40,  1'b1, 1'b1};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h44,  1'b0, 1'b0};

    rst = 1'b1;
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = 32'h0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = 32'h0;
    bus.upd_ghr      = '0;
    bus.upd_pred     = 1'b0;
    bus.upd_taken    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.lookup_pc = 32'h40;
    #1;
    check("reset_pred", {31'd0, bus.pred_taken}, 32'd0);
    check("reset_ghr", {26'd0, bus.pred_ghr}, 32'd0);
    check("reset_total", bus.preds_total, 32'd0);
    check("reset_succeed", bus.preds_succeed, 32'd0);
    check("reset_fail", bus.preds_fail, 32'd0);
    @(posedge clk);
    #1;

`ifndef GSHARE_EN
    // Mispredicts move the history in the gshare build, so the plain-index table runs only here.
    for (int i = 0; i < 17; i++) apply(vecs[i], i);
    bus.lookup_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ghr_tied", {26'd0, bus.pred_ghr}, 32'd0);
    bus.lookup_valid = 1'b0;
`else
    apply('{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0}, 0);
    apply('{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0}, 1);
`endif

    // Reset in the middle of traffic, with a simultaneous update that must be dropped.
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h40;
    bus.upd_pred  = 1'b1;
    bus.upd_taken = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.upd_valid = 1'b0;
    check("rst_total", bus.preds_total, 32'd0);
    check("rst_succeed", bus.preds_succeed, 32'd0);
    check("rst_fail", bus.preds_fail, 32'd0);
    check("rst_ghr", {26'd0, bus.pred_ghr}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      bus.lookup_pc = 32'(i) << 2;
      #1;
      check($sformatf("rst_pred[%0d]", i), {31'd0, bus.pred_taken}, 32'd0);
    end
    exp_t = 0; exp_s = 0; exp_f = 0;
    apply('{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0}, 100);
    apply('{1'b0, 32'h00, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0}, 101);

`ifdef GSHARE_EN
    // Entry 16 is WT: history 0 -> lookup 0x40 predicts 1, then 0x44 ^ 1 hits entry 16 again.
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h40;
    #1;
    check("gs_pred0", {31'd0, bus.pred_taken}, 32'd1);
    @(posedge clk);
    #1;
    check("gs_ghr1", {26'd0, bus.pred_ghr}, 32'd1);
    bus.lookup_pc = 32'h44;
    #1;
    check("gs_pred1", {31'd0, bus.pred_taken}, 32'd1);
    @(posedge clk);
    #1;
    check("gs_ghr3", {26'd0, bus.pred_ghr}, 32'd3);
    bus.lookup_pc = 32'h40;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h40;
    bus.upd_ghr   = 6'b000001;
    bus.upd_pred  = 1'b1;
    bus.upd_taken = 1'b0;
    #1;
    check("gs_mis", {31'd0, bus.mispredict}, 32'd1);
    @(posedge clk);
    #1;
    bus.upd_valid    = 1'b0;
    bus.lookup_valid = 1'b0;
    check("gs_ghr_repair", {26'd0, bus.pred_ghr}, 32'd2);
    check("gs_total", bus.preds_total, 32'd2);
    check("gs_fail", bus.preds_fail, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
